// File: rtl/rr_mux_arbiter.sv
// NUM_CH-channel registered mux with valid/ready handshaking. Source is picked by round-robin or fixed select.
// Define RR_MUX_STATS_EN to add the saturating xfer_cnt output-handshake counter.
module rr_mux_arbiter #(
  parameter int NUM_CH     = 5,
  parameter int DATA_WIDTH = 3,
  parameter int SEL_W      = (NUM_CH > 2) ? $clog2(NUM_CH) : 1,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic [SEL_W-1:0]             s,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]             out_ch,
  input  logic                         out_ready
`ifdef RR_MUX_STATS_EN
  ,
  output logic [CNT_W-1:0]             xfer_cnt
`endif
);

  localparam int              PAD_W    = 1 << SEL_W;
  localparam logic [SEL_W:0]  NUM_CH_X = (SEL_W + 1)'(NUM_CH);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  if (NUM_CH < 2 || CNT_W < 1) begin : g_bad_params
    $error("rr_mux_arbiter: NUM_CH must be >= 2 and CNT_W >= 1");
  end

  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [SEL_W-1:0]      out_ch_q, out_ch_d;
  logic [SEL_W-1:0]      rr_ptr_q, rr_ptr_d;

  logic [DATA_WIDTH-1:0] data_arr [NUM_CH];
  logic [SEL_W-1:0]      cand [NUM_CH];
  logic [PAD_W-1:0]      valid_pad;
  logic                  gnt_valid;
  logic [SEL_W-1:0]      gnt;
  logic                  load;

  // Zero-padded valids let any SEL_W-bit index be looked up safely (s >= NUM_CH reads 0).
  assign valid_pad = PAD_W'(in_valid);

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [SEL_W:0] sum;
    assign data_arr[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
    assign sum          = {1'b0, rr_ptr_q} + (SEL_W + 1)'(gi);
    assign cand[gi]     = (sum >= NUM_CH_X) ? SEL_W'(sum - NUM_CH_X) : sum[SEL_W-1:0];
  end

  // Round-robin: scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    if (mode) begin
      if (({1'b0, s} < NUM_CH_X) && valid_pad[s]) begin
        gnt_valid = 1'b1;
        gnt       = s;
      end
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (valid_pad[cand[k]]) begin
          gnt_valid = 1'b1;
          gnt       = cand[k];
        end
      end
    end
  end

  assign load = !out_valid_q || out_ready;

  always_comb begin
    in_ready = '0;
    if (load && gnt_valid && !rst) begin
      in_ready = NUM_CH'(1) << gnt;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    rr_ptr_d    = rr_ptr_q;
    if (load) begin
      if (gnt_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = data_arr[gnt];
        out_ch_d    = gnt;
        if (!mode) begin
          rr_ptr_d = (gnt == LAST_CH) ? '0 : gnt + 1'b1;
        end
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`ifdef RR_MUX_STATS_EN
  logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;

  always_comb begin
    xfer_cnt_d = xfer_cnt_q;
    if (out_valid_q && out_ready && (xfer_cnt_q != '1)) begin
      xfer_cnt_d = xfer_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt_q <= '0;
    end else begin
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Scoreboard bench for rr_mux_arbiter: directed vectors push expected words, a negedge monitor pops on handshakes.
module tb_rr_mux_arbiter;

  localparam int NUM_CH = 5;
  localparam int DW     = 3;
  localparam int SEL_W  = 3;
  localparam int CNT_W  = 4;

  logic                   clk;
  logic                   rst;
  logic                   mode;
  logic [SEL_W-1:0]       s;
  logic [NUM_CH-1:0]      in_valid;
  logic [NUM_CH*DW-1:0]   in_data;
  logic [NUM_CH-1:0]      in_ready;
  logic                   out_valid;
  logic [DW-1:0]          out_data;
  logic [SEL_W-1:0]       out_ch;
  logic                   out_ready;
`ifdef RR_MUX_STATS_EN
  logic [CNT_W-1:0]       xfer_cnt;
`endif

  rr_mux_arbiter #(
    .NUM_CH    (NUM_CH),
    .DATA_WIDTH(DW),
    .CNT_W     (CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .mode     (mode),
    .s        (s),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ch   (out_ch),
    .out_ready(out_ready)
`ifdef RR_MUX_STATS_EN
    ,
    .xfer_cnt (xfer_cnt)
`endif
  );

  typedef struct {
    int ch;
    int data;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input int ch, input int data);
    exp_t e;
    e.ch   = ch;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL out_word: got ch=%0d data=%0d, required no word", out_ch, out_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (out_ch !== SEL_W'(e.ch) || out_data !== DW'(e.data)) begin
          n_miss++;
          $display("FAIL out_word: got ch=%0d data=%0d, required ch=%0d data=%0d",
                   out_ch, out_data, e.ch, e.data);
        end else begin
          $display("word ch=%0d data=%0d ok", out_ch, out_data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    n_miss++;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1);
  end

  initial begin
    rst       = 1'b1;
    mode      = 1'b0;
    s         = '0;
    in_valid  = 5'b11111;
    out_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) in_data[i*DW +: DW] = DW'(i + 1);

    // Reset held with every channel valid
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_ch",    32'(out_ch),    32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd0);
      @(posedge clk);
    end
    #1;

    // Round-robin over all five channels
    push(0, 1); push(1, 2); push(2, 3); push(3, 4); push(4, 5); push(0, 1);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    #1 in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Round-robin wrap with channels 1 and 4 only
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 5'b10010;
    push(1, 2); push(4, 5); push(1, 2); push(4, 5);
    repeat (4) @(posedge clk);
    #1 in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Stall for three cycles while disturbing mode, s and in_valid
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 5'b11111;
    push(0, 1); push(1, 2); push(2, 3);
    tick();
    out_ready = 1'b0;
    mode      = 1'b1;
    s         = 3'd4;
    in_valid  = 5'b00110;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_out_ch",    32'(out_ch),    32'd0);
      check("stall_out_data",  32'(out_data),  32'd1);
      check("stall_in_ready",  32'(in_ready),  32'd0);
    end
    tick();
    out_ready = 1'b1;
    mode      = 1'b0;
    s         = '0;
    in_valid  = 5'b11111;
    repeat (2) @(posedge clk);
    #1 in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

    // Fixed select s=3, then out-of-range s=6
    mode     = 1'b1;
    s        = 3'd3;
    in_valid = 5'b11111;
    push(3, 4); push(3, 4); push(3, 4); push(3, 4);
    @(negedge clk);
    check("fixed_in_ready", 32'(in_ready), 32'h08);
    repeat (4) @(posedge clk);
    #1 s = 3'd6;
    @(posedge clk);
    @(negedge clk);
    check("s6_out_valid", 32'(out_valid), 32'd0);
    check("s6_in_ready",  32'(in_ready),  32'd0);
    check("s6_out_ch",    32'(out_ch),    32'd3);
    check("s6_out_data",  32'(out_data),  32'd4);

    // Back to round-robin: pointer was left at 3 by the earlier run
    tick();
    mode = 1'b0;
    s    = '0;
    push(3, 4); push(4, 5); push(0, 1);
    repeat (3) @(posedge clk);
    #1 in_valid = '0;
    repeat (2) @(posedge clk);
    #1;

`ifdef RR_MUX_STATS_EN
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("cnt_reset", 32'(xfer_cnt), 32'd0);
    for (int pass = 0; pass < 2; pass++) begin
      tick();
      rst      = 1'b0;
      in_valid = 5'b11111;
      for (int i = 0; i < 10; i++) push(i % 5, (i % 5) + 1);
      repeat (10) @(posedge clk);
      #1 in_valid = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("cnt_value", 32'(xfer_cnt), (pass == 0) ? 32'd10 : 32'd15);
    end
    tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("cnt_cleared", 32'(xfer_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();
`endif

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
